// File: rtl/ctrl_frame_receiver_if.sv
// picosoc iomem bus bundle; master is the CPU side, slave is the frame receiver.
interface ctrl_frame_receiver_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/ctrl_frame_receiver.sv
// Control-frame receiver: drains PHY-RX FIFO one byte/cycle into a 64-byte frame RAM with CRC-32 FCS check.
// Bus replies one cycle after a decoded request; FIFO empty simply stalls the receive FSM.
module ctrl_frame_receiver (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_fifo_dout,
  input  logic                 i_fifo_del,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rden,
  output logic                 o_irq,
  ctrl_frame_receiver_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_DROP, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        start;
  logic [10:0] byte_cnt;
  logic [31:0] shift_reg;
  logic [31:0] crc_reg;
  logic [31:0] crc_out;
  logic [31:0] ram [16];
  logic        rx_enable;
  logic        frame_valid;
  logic        fcs_ok;
  logic        oversize;
  logic [7:0]  drop_cnt;
  logic [10:0] frame_len;
  logic        sel_stat;
  logic        sel_ram;
  logic        bus_acc;
  logic        ack;
  logic        clr_drop;
  logic        en_wr;
  logic [31:0] status;
  logic        unused_ok;

  // CRC-32, polynomial 0x04C11DB7, MSB-first, init all-ones, output inverted.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    end
    return r;
  endfunction

  assign crc_out = ~crc_reg;
  assign o_irq   = frame_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_fifo_rden = 1'b0;
    start       = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_enable && !i_fifo_empty) begin
          if (frame_valid) begin
            state_nxt = S_DROP;
          end else begin
            state_nxt = S_RX;
            start     = 1'b1;
          end
        end
      end
      S_RX: begin
        o_fifo_rden = !i_fifo_empty;
        if (!i_fifo_empty && i_fifo_del) state_nxt = S_DONE;
      end
      S_DROP: begin
        o_fifo_rden = !i_fifo_empty;
        if (!i_fifo_empty && i_fifo_del) state_nxt = S_IDLE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (rst) o_fifo_rden = 1'b0;
  end

  assign sel_stat = (bus.iomem_addr[31:24] == 8'h16);
  assign sel_ram  = (bus.iomem_addr[31:24] == 8'h06);
  assign bus_acc  = bus.iomem_valid && !bus.iomem_ready && (sel_stat || sel_ram);
  assign en_wr    = bus_acc && sel_stat && bus.iomem_wstrb[3];
  assign ack      = en_wr && bus.iomem_wdata[28];
  assign clr_drop = bus_acc && sel_stat && bus.iomem_wstrb[2] && bus.iomem_wdata[16];
  assign status   = {rx_enable, frame_valid, (state != S_IDLE), 1'b0, fcs_ok, oversize,
                     2'b00, drop_cnt, 5'b00000, frame_len};

  assign unused_ok = ^{bus.iomem_addr[23:6], bus.iomem_addr[1:0], bus.iomem_wstrb[1:0],
                       bus.iomem_wdata[30:29], bus.iomem_wdata[27:17], bus.iomem_wdata[15:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt        <= '0;
      shift_reg       <= '0;
      crc_reg         <= 32'hFFFF_FFFF;
      rx_enable       <= 1'b0;
      frame_valid     <= 1'b0;
      fcs_ok          <= 1'b0;
      oversize        <= 1'b0;
      drop_cnt        <= '0;
      frame_len       <= '0;
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= '0;
      for (int w = 0; w < 16; w++) ram[w] <= '0;
    end else begin
      if (start) begin
        byte_cnt  <= '0;
        shift_reg <= '0;
        crc_reg   <= 32'hFFFF_FFFF;
      end else if (state == S_RX && o_fifo_rden) begin
        if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
        shift_reg <= {shift_reg[23:0], i_fifo_dout};
        // The four newest bytes are the FCS candidate, so only older bytes enter the CRC.
        if (byte_cnt >= 11'd4) crc_reg <= crc32_byte(crc_reg, shift_reg[31:24]);
        if (byte_cnt < 11'd64) ram[byte_cnt[5:2]][{byte_cnt[1:0], 3'b000} +: 8] <= i_fifo_dout;
      end

      if (state == S_DONE) begin
        frame_len <= byte_cnt;
        fcs_ok    <= (byte_cnt >= 11'd5) && (crc_out == shift_reg);
        oversize  <= (byte_cnt > 11'd64);
      end

      if (state == S_DONE) frame_valid <= 1'b1;
      else if (ack)        frame_valid <= 1'b0;

      if (clr_drop) begin
        drop_cnt <= '0;
      end else if (state == S_DROP && o_fifo_rden && i_fifo_del && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      if (en_wr) rx_enable <= bus.iomem_wdata[31];

      bus.iomem_ready <= bus_acc;
      if (bus_acc) bus.iomem_rdata <= sel_stat ? status : ram[bus.iomem_addr[5:2]];
    end
  end

endmodule

// File: tb/tb_ctrl_frame_receiver.sv
// Randomized bench for ctrl_frame_receiver with a frame-level reference model.
module tb_ctrl_frame_receiver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i_fifo_dout = 8'h00;
  logic       i_fifo_del = 1'b0;
  logic       i_fifo_empty = 1'b1;
  logic       o_fifo_rden;
  logic       o_irq;

  ctrl_frame_receiver_if bus ();

  ctrl_frame_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .i_fifo_dout  (i_fifo_dout),
    .i_fifo_del   (i_fifo_del),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rden  (o_fifo_rden),
    .o_irq        (o_irq),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic        m_rx_en, m_fv, m_fcs, m_ovs;
  logic [7:0]  m_drop;
  logic [10:0] m_len;
  logic [31:0] m_ram [16];

  logic [7:0]  frm [$];
  logic [8:0]  fifo_q [$];
  logic        gap_en = 1'b0;
  logic        hold = 1'b0;
  logic        rden_s = 1'b0;
  int          pop_cnt = 0;
  int          stop_at = -1;
  logic        settled = 1'b0;
  logic        exp_chk = 1'b0;
  logic [31:0] exp_rdata = '0;
  string       exp_name = "none";

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int b = 7; b >= 0; b--)
        c = (c[31] ^ frm[i][b]) ? ({c[30:0], 1'b0} ^ 32'h04C11DB7) : {c[30:0], 1'b0};
    return ~c;
  endfunction

  function automatic logic [31:0] m_status();
    return {m_rx_en, m_fv, 2'b00, m_fcs, m_ovs, 2'b00, m_drop, 5'b00000, m_len};
  endfunction

  task automatic model_reset();
    m_rx_en = 0; m_fv = 0; m_fcs = 0; m_ovs = 0; m_drop = 0; m_len = 0;
    for (int w = 0; w < 16; w++) m_ram[w] = '0;
  endtask

  // FIFO behaviour: pop on the edge where the DUT strobed, random empty gaps when enabled.
  always @(posedge clk) begin
    if (rden_s && fifo_q.size() > 0) begin
      fifo_q.delete(0);
      pop_cnt++;
      if (pop_cnt == stop_at) hold = 1'b1;
    end
    #1;
    i_fifo_empty = hold || (gap_en && $urandom_range(0, 3) == 0) || fifo_q.size() == 0;
    if (fifo_q.size() > 0) {i_fifo_del, i_fifo_dout} = fifo_q[0];
    else                   {i_fifo_del, i_fifo_dout} = 9'h000;
  end

  always @(negedge clk) rden_s = o_fifo_rden;

  // compare process
  always @(negedge clk) begin
    if (exp_chk && bus.iomem_ready) check(exp_name, bus.iomem_rdata, exp_rdata);
    if (settled && !rst) check("irq_level", {31'b0, o_irq}, {31'b0, m_fv});
    if (i_fifo_empty) check("pop_while_empty", {31'b0, o_fifo_rden}, 32'h0);
  end

  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic chk, input logic [31:0] exp, input string nm);
    int t;
    @(posedge clk); #1;
    bus.iomem_valid = 1'b1; bus.iomem_addr = a; bus.iomem_wdata = wd; bus.iomem_wstrb = ws;
    exp_rdata = exp; exp_chk = chk; exp_name = nm;
    t = 0;
    @(negedge clk);
    while (!bus.iomem_ready && t < 20) begin @(negedge clk); t++; end
    if (!bus.iomem_ready) begin
      n_chk++; n_fail++;
      $display("FAIL bus_timeout %s: got no ready required ready within 20 cycles", nm);
    end
    @(posedge clk); #1;
    bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0; exp_chk = 1'b0;
  endtask

  task automatic bus_noresp(input logic [31:0] a);
    int seen;
    @(posedge clk); #1;
    bus.iomem_valid = 1'b1; bus.iomem_addr = a; bus.iomem_wstrb = 4'h0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (bus.iomem_ready) seen++; end
    check("noresp_ready_count", seen, 0);
    @(posedge clk); #1;
    bus.iomem_valid = 1'b0;
  endtask

  task automatic rd_stat(input string nm, input logic [31:0] exp);
    bus_xfer(32'h1600_0000, 32'h0, 4'h0, 1'b1, exp, nm);
  endtask

  task automatic rd_word(input int w, input string nm, input logic [31:0] exp);
    bus_xfer(32'h0600_0000 | (w << 2), 32'h0, 4'h0, 1'b1, exp, nm);
  endtask

  task automatic wr_enable(input logic en);
    bus_xfer(32'h1600_0000, {en, 31'b0}, 4'b1000, 1'b0, 32'h0, "wr_en");
    m_rx_en = en;
  endtask

  task automatic do_ack();
    settled = 1'b0;
    bus_xfer(32'h1600_0000, {m_rx_en, 2'b00, 1'b1, 28'b0}, 4'b1000, 1'b0, 32'h0, "ack");
    m_fv = 1'b0;
    @(negedge clk);
    settled = 1'b1;
  endtask

  task automatic mk_frame(input int n, input bit rnd, input bit good);
    int nd;
    logic [31:0] c;
    frm.delete();
    nd = (n >= 4) ? n - 4 : n;
    for (int i = 0; i < nd; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i));
    if (n >= 4) begin
      c = crc_of(nd);
      if (!good) c = ~c;
      frm.push_back(c[31:24]); frm.push_back(c[23:16]);
      frm.push_back(c[15:8]);  frm.push_back(c[7:0]);
    end
  endtask

  // Frame-level outcome: dropped while a frame is pending, otherwise stored and checked.
  task automatic send_frame();
    int n;
    n = frm.size();
    settled = 1'b0;
    if (m_fv) begin
      if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end else begin
      m_fv  = 1'b1;
      m_len = (n > 2047) ? 11'd2047 : 11'(n);
      m_ovs = (n > 64);
      m_fcs = (n >= 5) && (crc_of(n - 4) == {frm[n-4], frm[n-3], frm[n-2], frm[n-1]});
      for (int k = 0; k < n && k < 64; k++) m_ram[k / 4][8 * (k % 4) +: 8] = frm[k];
    end
    for (int i = 0; i < n; i++) fifo_q.push_back({(i == n - 1), frm[i]});
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (fifo_q.size() != 0 && t < 6000) begin @(negedge clk); t++; end
    if (fifo_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: got %0d bytes left required 0", fifo_q.size());
      fifo_q.delete();
    end
    repeat (4) @(negedge clk);
    settled = 1'b1;
  endtask

  task automatic check_all(input string tag);
    rd_stat({tag, "_status"}, m_status());
    for (int w = 0; w < 16; w++) rd_word(w, $sformatf("%s_word%0d", tag, w), m_ram[w]);
  endtask

  initial begin
    int t;
    bus.iomem_valid = 1'b0; bus.iomem_wstrb = 4'h0; bus.iomem_addr = '0; bus.iomem_wdata = '0;
    model_reset();

    // pin the CRC definition: CRC-32/BZIP2 check value
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
    check("crc_model_check", crc_of(9), 32'hFC89_1918);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_irq", {31'b0, o_irq}, 32'h0);
    check("rst_rden", {31'b0, o_fifo_rden}, 32'h0);
    check("rst_ready", {31'b0, bus.iomem_ready}, 32'h0);
    check("rst_rdata", bus.iomem_rdata, 32'h0);
    settled = 1'b1;
    rd_stat("rst_status", 32'h0);
    rd_word(0, "rst_word0", 32'h0);
    bus_noresp(32'h2600_0000);

    wr_enable(1'b1);
    bus_xfer(32'h0600_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, "ram_write_ignored");

    // 60 counting bytes + good FCS
    mk_frame(64, 0, 1); send_frame(); wait_drain();
    check("a_irq", {31'b0, o_irq}, 32'h1);
    rd_stat("a_status_lit", 32'hC800_0040);
    rd_word(0, "a_word0_lit", 32'h0302_0100);
    check_all("a");

    do_ack();
    mk_frame(64, 0, 1); frm[10] = frm[10] ^ 8'h01; send_frame(); wait_drain();
    rd_stat("b_status_lit", 32'hC000_0040);
    check_all("b");

    do_ack();
    mk_frame(100, 0, 1); send_frame(); wait_drain();
    rd_stat("c_status_lit", 32'hCC00_0064);
    rd_word(15, "c_word15_lit", 32'h3F3E_3D3C);
    check_all("c");

    // arrives while a frame is pending
    mk_frame(30, 1, 1); send_frame(); wait_drain();
    rd_stat("d_status_lit", 32'hCC01_0064);
    check_all("d");

    do_ack();
    check("ack_irq", {31'b0, o_irq}, 32'h0);
    mk_frame(50, 1, 1); send_frame(); wait_drain();
    check_all("e");

    // disable mid-frame: frame still completes
    do_ack();
    mk_frame(40, 1, 1);
    t = pop_cnt;
    send_frame();
    while (pop_cnt < t + 10 && pop_cnt < t + 40) @(negedge clk);
    wr_enable(1'b0);
    wait_drain();
    check_all("dis");
    wr_enable(1'b1);

    // drop counter clear without touching rx_enable
    bus_xfer(32'h1600_0000, 32'h0001_0000, 4'b0100, 1'b0, 32'h0, "clr_drop");
    m_drop = 8'h00;
    do_ack();
    gap_en = 1'b1;
    mk_frame(64, 0, 1); send_frame(); wait_drain();
    rd_stat("gap_a_status_lit", 32'hC800_0040);
    check_all("gap_a");

    for (int f = 0; f < 8; f++) begin
      if (m_fv && $urandom_range(0, 1) == 1) do_ack();
      mk_frame($urandom_range(1, 120), 1, $urandom_range(0, 1) == 1);
      send_frame(); wait_drain();
      check_all($sformatf("rnd%0d", f));
    end
    gap_en = 1'b0;

    // byte counter saturation
    do_ack();
    mk_frame(2100, 1, 1); send_frame(); wait_drain();
    check_all("sat");

    // reset after byte 20 of a 40-byte frame
    do_ack();
    mk_frame(40, 0, 1);
    stop_at = pop_cnt + 20;
    send_frame();
    t = 0;
    while (!hold && t < 500) begin @(negedge clk); t++; end
    check("hold_reached", {31'b0, hold}, 32'h1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    hold = 1'b0; stop_at = -1;
    @(negedge clk);
    settled = 1'b1;
    check("mid_rst_irq", {31'b0, o_irq}, 32'h0);
    rd_stat("mid_rst_status", 32'h0);
    rd_word(0, "mid_rst_word0", 32'h0);
    check("mid_rst_left", fifo_q.size(), 20);
    frm.delete();
    foreach (fifo_q[i]) frm.push_back(fifo_q[i][7:0]);
    fifo_q.delete();
    wr_enable(1'b1);
    send_frame(); wait_drain();
    check_all("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_frame_receiver.md
CTRL_FRAME_RECEIVER -- requirements
Module: ctrl_frame_receiver

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 SHALL have i_fifo_dout  input  8  PHY-RX FIFO head byte (first-word-fall-through, valid whenever i_fifo_empty=0).
REQ-003 SHALL have i_fifo_del  input  1  end-of-frame delimiter, qualifies the current head byte as the last byte of its frame.
REQ-004 SHALL have i_fifo_empty  input  1  FIFO empty flag.
REQ-005 SHALL have o_fifo_rden  output  1  pop strobe; one byte consumed per cycle asserted.
REQ-006 SHALL have o_irq  output  1  level, equals frame_valid.
REQ-007 SHALL have the picosoc port: iomem_valid in 1; iomem_ready out 1; iomem_wstrb in 4; iomem_addr in 32; iomem_wdata in 32; iomem_rdata out 32.

Function
REQ-008 SHALL decode iomem_addr[31:24]==8'h16 as the status register and 8'h06 as the 16x32 frame RAM (word = iomem_addr[5:2], read-only, writes ignored); other addresses get no response.
REQ-009 SHALL pulse iomem_ready for exactly one cycle, the cycle after iomem_valid is sampled with iomem_ready=0 and a decoded address; iomem_rdata updates on that same edge.
REQ-010 Status register SHALL read: [31] rx_enable RW; [30] frame_valid R; [29] busy R (state!=S_IDLE); [28] ack W (reads 0); [27] fcs_ok R; [26] oversize R; [23:16] drop_cnt R; [10:0] frame_len R; other bits 0.
REQ-011 Status writes SHALL take effect only when iomem_wstrb[3]=1 (bits 31, 28); writing 1 to bit 16 with iomem_wstrb[2]=1 SHALL clear drop_cnt.
REQ-012 FSM states SHALL be S_IDLE, S_RX, S_DROP, S_DONE.
REQ-013 S_IDLE: if rx_enable=1 and i_fifo_empty=0, go S_DROP when frame_valid=1, else go S_RX clearing byte counter, shift register and CRC; no pop in S_IDLE.
REQ-014 S_RX/S_DROP: o_fifo_rden = ~i_fifo_empty (combinational); empty cycles stall with no state change.
REQ-015 S_RX: popped byte k (k<64) SHALL be written to RAM word k[5:2], bits [8*k[1:0]+7 : 8*k[1:0]] (little-endian); bytes k>=64 not stored.
REQ-016 Byte counter SHALL be 11 bits, saturating at 2047.
REQ-017 S_RX: each popped byte SHALL shift into a 32-bit register; the byte shifted out (5th-most-recent) SHALL feed the existing crc block (crc_en=1), so the CRC covers all bytes except the last four.
REQ-018 S_RX: pop with i_fifo_del=1 SHALL go to S_DONE.
REQ-019 S_DONE (one cycle): frame_len=count; fcs_ok=(count>=5 and crc_out==shift register, first-received FCS byte as [31:24]); oversize=(count>64); frame_valid=1; go S_IDLE.
REQ-020 S_DROP: pops until i_fifo_del pop, then drop_cnt+=1 (saturating at 255), go S_IDLE; RAM and status fields unchanged.
REQ-021 ack=1 SHALL clear frame_valid; it SHALL be ignored when frame_valid=0.
REQ-022 rx_enable cleared mid-frame SHALL not abort; the current frame completes (S_RX or S_DROP).
REQ-023 Frame RAM contents SHALL persist until overwritten by the next accepted frame.

Reset
REQ-024 rst=1 SHALL force S_IDLE, o_fifo_rden=0, o_irq=0, iomem_ready=0, iomem_rdata=0, rx_enable=0, frame_valid=0, fcs_ok=0, oversize=0, drop_cnt=0, frame_len=0, CRC reset, RAM cleared to 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; remaining FIFO bytes are treated as a new frame once enabled.

Verification
REQ-026 Reset: assert rst 2 cycles -> all outputs and status read 32'h0.
REQ-027 Enable, feed 60 bytes 0x00..0x3B plus correct 4-byte FCS, del on last -> frame_valid=1, o_irq=1, frame_len=64, fcs_ok=1, oversize=0; word 0 reads 32'h03020100.
REQ-028 Same frame with byte 10 flipped -> fcs_ok=0, frame_len=64, frame_valid=1.
REQ-029 100-byte frame, valid FCS -> frame_len=100, oversize=1, fcs_ok=1, word 15 = bytes 60..63.
REQ-030 Second frame while frame_valid=1 -> drained, drop_cnt=1, RAM unchanged; write ack -> frame_valid=0, o_irq=0; third frame accepted.
REQ-031 Insert empty gaps mid-frame -> no pops during gaps, identical results; rst at byte 20 -> S_IDLE, frame_valid=0.
